rr_select_mux: RTL and testbench
================================

# rr_select_mux

Parametrised N-channel, W-bit registered selector and successor to the fixed 4:1 16-bit mux. It chooses one of `CHANNELS` valid/ready input streams, either by an explicit select (fixed mode) or by round-robin arbitration, and registers the winner into a single output stage. Typical uses are register-file read muxing, writeback source selection and shared-bus access in the processor datapath, wherever a producer may stall.

## Interface
- `WIDTH`, 16: data width per channel, ≥1.
- `CHANNELS`, 4: number of input channels, 2..16.
- `SELW`, `$clog2(CHANNELS)`: select/channel-index width (derived; do not override).

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in_data`  in  `CHANNELS*WIDTH`  flattened inputs; channel i occupies bits `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  `CHANNELS`  per-channel valid.
- `in_ready`  out  `CHANNELS`  per-channel ready; one-hot or zero.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `sel`  in  `SELW`  channel index used in fixed mode.
- `out_data`  out  `WIDTH`  registered selected data.
- `out_chan`  out  `SELW`  index of the channel that produced `out_data`.
- `out_valid`  out  1  output register holds a beat.
- `out_ready`  in  1  downstream accepts the beat.

## Operation
- **Output stage.** One entry, states EMPTY (`out_valid`=0) and FULL (`out_valid`=1).
  - `can_load = !out_valid || out_ready`.
- **Arbitration** is evaluated combinationally each cycle and only when `can_load`=1.
  - **Fixed mode.** `grant = onehot(sel)` if `in_valid[sel]` and `sel < CHANNELS`, else no grant. `sel ≥ CHANNELS` never grants.
  - **Round-robin mode.** Scan from pointer `rr_ptr` upward, wrapping at `CHANNELS-1` to 0. The first channel with `in_valid` wins.
- `in_ready = grant`. A transfer on channel i happens when `in_valid[i] && in_ready[i]`.
- **On a transfer:**
  - `out_data <= in_data[i]`, `out_chan <= i`, `out_valid <= 1`.
  - In round-robin mode, `rr_ptr <= (i+1) mod CHANNELS`, wrapping from `CHANNELS-1` to 0.
  - Fixed-mode transfers do not move `rr_ptr`.
- **On `out_valid && out_ready` with no new transfer:** `out_valid <= 0`. `out_data` and `out_chan` hold their last values.
- **No grant:** `rr_ptr` is unchanged. The output follows the pop rule above.
- **Stall** (`out_valid && !out_ready`):
  - `in_ready` is all-zero.
  - `out_data` and `out_chan` are held bit-stable.
- **Simultaneous pop and load:** allowed. The new beat replaces the old with no bubble.
- **Mode and `sel` changes:** `mode` and `sel` are sampled every cycle. A change affects only the next grant and never the held output beat.
- **Data handling:** data passes through unmodified, with no sign or width conversion.

## Timing
- Latency: 1 cycle from input handshake to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready`=1.
- `in_ready` is combinational from `in_valid`, `mode`, `sel`, `rr_ptr`, `out_valid` and `out_ready`. There is no combinational path from `in_data` to any output.
- **Reset values** (asynchronous on `rst_n`=0, independent of `clk`):
  - `out_valid`=0, `out_data`=0, `out_chan`=0, `rr_ptr`=0.
  - `in_ready`=0 while `rst_n`=0.
- **Reset mid-operation:** a held beat is discarded and `out_valid` drops immediately. The first grant after `rst_n` rises starts the round-robin scan at channel 0.
- **Reset release:** synchronise it upstream. The block assumes deassertion is clean relative to `clk`.

## Test plan
- **Reset state:** assert `rst_n`=0 with all `in_valid`=1. Require `out_valid`=0, `out_data`=0, `out_chan`=0 and `in_ready`=0. Release; next edge, round-robin mode: `out_chan`=0, `out_data`=`in_data[0]`.
- **Fixed mode:** `CHANNELS`=4, `WIDTH`=16, `mode`=0, `sel`=2, channel 2 data `16'h8001` valid, `out_ready`=1. Require `in_ready`=`4'b0100`, one cycle later `out_data`=`16'h8001`, `out_chan`=2. Then `in_valid[2]`=0: no grant and `out_valid` falls next cycle.
- **Round-robin fairness and wrap:** all four channels valid continuously, `out_ready`=1, `mode`=1. Require `out_chan` sequence 0,1,2,3,0,1 on consecutive cycles with no bubbles. With only channels 1 and 3 valid, require 1,3,1,3.
- **Backpressure:** a beat `16'h1234` is held and `out_ready`=0 for 5 cycles with all inputs valid. Require `in_ready`=0, `out_data`=`16'h1234` stable and `rr_ptr` unchanged. With `out_ready`=1, the next channel in sequence loads the same cycle the old beat pops.
- **Out-of-range select:** `CHANNELS`=3, `mode`=0, `sel`=3 with all valid. Require `in_ready`=0 and no `out_valid` for 4 cycles.
- **Async reset mid-stream:** pulse `rst_n` low between edges during round-robin streaming. Require `out_valid`=0 immediately, before the next edge. After release, arbitration restarts at channel 0.

Source files
------------

// File: rtl/rr_select_mux.sv
// Registered N-channel valid/ready selector with fixed-select and round-robin modes.
// One output register; in_ready is the combinational grant, data is never on a comb path to outputs.
module rr_select_mux #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4,
  parameter int SELW     = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  output logic [WIDTH-1:0]          out_data,
  output logic [SELW-1:0]           out_chan,
  output logic                      out_valid,
  input  logic                      out_ready
);

  logic                can_load_s;
  logic                hi_found_s;
  logic                lo_found_s;
  logic                fix_found_s;
  logic                found_s;
  logic [SELW-1:0]     hi_win_s;
  logic [SELW-1:0]     lo_win_s;
  logic [SELW-1:0]     fix_win_s;
  logic [SELW-1:0]     win_s;
  logic [SELW-1:0]     next_ptr_s;
  logic [CHANNELS-1:0] grant_s;
  logic [WIDTH-1:0]    mux_data_s;

  logic [SELW-1:0]     rr_ptr_r;
  logic [SELW-1:0]     out_chan_r;
  logic [WIDTH-1:0]    out_data_r;
  logic                out_valid_r;

  // Gating by rst_n keeps in_ready low for the whole reset interval.
  assign can_load_s = rst_n & (~out_valid_r | out_ready);

  // Candidate winners: lowest valid at/above rr_ptr, lowest valid overall, and the fixed select.
  always_comb begin
    hi_found_s  = 1'b0;
    hi_win_s    = '0;
    lo_found_s  = 1'b0;
    lo_win_s    = '0;
    fix_found_s = 1'b0;
    fix_win_s   = '0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (in_valid[i]) begin
        lo_found_s = 1'b1;
        lo_win_s   = SELW'(i);
        if (SELW'(i) >= rr_ptr_r) begin
          hi_found_s = 1'b1;
          hi_win_s   = SELW'(i);
        end else begin
          hi_found_s = hi_found_s;
        end
      end else begin
        lo_found_s = lo_found_s;
      end
      // sel values beyond CHANNELS-1 never match any loop index, so they never grant.
      if (in_valid[i] && (sel == SELW'(i))) begin
        fix_found_s = 1'b1;
        fix_win_s   = SELW'(i);
      end else begin
        fix_found_s = fix_found_s;
      end
    end
  end

  // Final arbitration: the wrap-around scan falls back to the lowest valid channel.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    if (!can_load_s) begin
      found_s = 1'b0;
    end else if (mode) begin
      if (hi_found_s) begin
        found_s = 1'b1;
        win_s   = hi_win_s;
      end else if (lo_found_s) begin
        found_s = 1'b1;
        win_s   = lo_win_s;
      end else begin
        found_s = 1'b0;
      end
    end else begin
      found_s = fix_found_s;
      win_s   = fix_win_s;
    end
  end

  // One-hot grant, winner data mux and successor pointer.
  always_comb begin
    grant_s    = '0;
    mux_data_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (win_s == SELW'(i)) begin
        grant_s[i] = found_s;
        mux_data_s = in_data[i*WIDTH +: WIDTH];
      end else begin
        grant_s[i] = 1'b0;
      end
    end
    if (win_s == SELW'(CHANNELS - 1)) begin
      next_ptr_s = '0;
    end else begin
      next_ptr_s = win_s + SELW'(1);
    end
  end

  assign in_ready = grant_s;

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_r  <= '0;
      out_chan_r  <= '0;
      out_valid_r <= 1'b0;
      rr_ptr_r    <= '0;
    end else if (found_s) begin
      out_data_r  <= mux_data_s;
      out_chan_r  <= win_s;
      out_valid_r <= 1'b1;
      if (mode) begin
        rr_ptr_r <= next_ptr_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
    end else begin
      out_valid_r <= out_valid_r;
    end
  end

  assign out_data  = out_data_r;
  assign out_chan  = out_chan_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_rr_select_mux.sv
// Self-checking bench for rr_select_mux: a 4-channel instance checked against a scoreboard
// model, and a 3-channel instance for the out-of-range select case.
module tb_rr_select_mux;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 4-channel, 16-bit instance
  logic        rst4_n;
  logic [63:0] in_data4;
  logic [3:0]  in_valid4;
  logic [3:0]  in_ready4;
  logic        mode4;
  logic [1:0]  sel4;
  logic [15:0] out_data4;
  logic [1:0]  out_chan4;
  logic        out_valid4;
  logic        out_ready4;

  // 3-channel, 16-bit instance
  logic        rst3_n;
  logic [47:0] in_data3;
  logic [2:0]  in_valid3;
  logic [2:0]  in_ready3;
  logic        mode3;
  logic [1:0]  sel3;
  logic [15:0] out_data3;
  logic [1:0]  out_chan3;
  logic        out_valid3;
  logic        out_ready3;

  rr_select_mux #(.WIDTH(16), .CHANNELS(4)) u_dut4 (
    .clk(clk), .rst_n(rst4_n), .in_data(in_data4), .in_valid(in_valid4), .in_ready(in_ready4),
    .mode(mode4), .sel(sel4), .out_data(out_data4), .out_chan(out_chan4),
    .out_valid(out_valid4), .out_ready(out_ready4));

  rr_select_mux #(.WIDTH(16), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .mode(mode3), .sel(sel3), .out_data(out_data3), .out_chan(out_chan3),
    .out_valid(out_valid3), .out_ready(out_ready3));

  typedef struct {
    logic        v;
    logic [15:0] d;
    logic [1:0]  c;
  } beat_t;

  beat_t       sbq[$];
  beat_t       e;
  int          total = 0;
  int          bad   = 0;

  // Reference model state for the 4-channel instance
  int          m_ptr;
  logic        m_valid;
  logic [15:0] m_data;
  logic [1:0]  m_chan;
  logic [3:0]  exp_rdy;

  task automatic model_reset();
    m_ptr   = 0;
    m_valid = 1'b0;
    m_data  = 16'h0000;
    m_chan  = 2'd0;
    sbq.delete();
  endtask

  // Predict this cycle's grant from the current inputs and push the post-edge output.
  task automatic model_step();
    logic cl;
    logic found;
    int   w;
    cl    = !m_valid || out_ready4;
    found = 1'b0;
    w     = 0;
    if (cl) begin
      if (mode4) begin
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (!found && in_valid4[c]) begin
            found = 1'b1;
            w     = c;
          end
        end
      end else if (in_valid4[sel4]) begin
        found = 1'b1;
        w     = int'(sel4);
      end
    end
    exp_rdy = found ? 4'(1 << w) : 4'b0000;
    if (found) begin
      m_valid = 1'b1;
      m_data  = in_data4[w*16 +: 16];
      m_chan  = 2'(w);
      if (mode4) m_ptr = (w + 1) % 4;
    end else if (m_valid && out_ready4) begin
      m_valid = 1'b0;
    end
    sbq.push_back('{m_valid, m_data, m_chan});
  endtask

  task automatic test_reset();
    rst4_n     = 1'b0;
    in_valid4  = 4'b1111;
    mode4      = 1'b1;
    sel4       = 2'd0;
    out_ready4 = 1'b1;
    in_data4   = {16'hC303, 16'h8001, 16'hA101, 16'h1234};
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_valid4 !== 1'b0 || out_data4 !== 16'h0000 || out_chan4 !== 2'd0) begin
      bad++;
      $display("FAIL reset_out got v=%b d=%h c=%0d exp v=0 d=0000 c=0", out_valid4, out_data4, out_chan4);
    end
    total++;
    if (in_ready4 !== 4'b0000) begin
      bad++;
      $display("FAIL reset_in_ready got=%b exp=0000", in_ready4);
    end
    rst4_n = 1'b1;
    #1;
    model_step();
    total++;
    if (in_ready4 !== exp_rdy) begin
      bad++;
      $display("FAIL reset_first_grant got=%b exp=%b", in_ready4, exp_rdy);
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    total++;
    if (out_valid4 !== 1'b1 || out_chan4 !== 2'd0 || out_data4 !== 16'h1234 || out_data4 !== e.d) begin
      bad++;
      $display("FAIL reset_first_beat got v=%b d=%h c=%0d exp v=1 d=1234 c=0", out_valid4, out_data4, out_chan4);
    end
  endtask

  task automatic test_fixed();
    mode4     = 1'b0;
    sel4      = 2'd2;
    in_valid4 = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) in_valid4 = 4'b0000;
      #1;
      model_step();
      total++;
      if (in_ready4 !== exp_rdy || (i == 0 && in_ready4 !== 4'b0100)) begin
        bad++;
        $display("FAIL fixed_in_ready[%0d] got=%b exp=%b", i, in_ready4, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (out_valid4 !== e.v || out_data4 !== e.d || out_chan4 !== e.c) begin
        bad++;
        $display("FAIL fixed_beat[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 i, out_valid4, out_data4, out_chan4, e.v, e.d, e.c);
      end
    end
  endtask

  task automatic test_round_robin();
    int seq[6] = '{0, 1, 2, 3, 0, 1};
    rst4_n = 1'b0;
    model_reset();
    #3;
    rst4_n     = 1'b1;
    mode4      = 1'b1;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) in_valid4 = 4'b1010;
      #1;
      model_step();
      total++;
      if (in_ready4 !== exp_rdy) begin
        bad++;
        $display("FAIL rr_in_ready[%0d] got=%b exp=%b", i, in_ready4, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (out_valid4 !== e.v || out_data4 !== e.d || out_chan4 !== e.c) begin
        bad++;
        $display("FAIL rr_beat[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 i, out_valid4, out_data4, out_chan4, e.v, e.d, e.c);
      end
      if (i < 6) begin
        total++;
        if (out_valid4 !== 1'b1 || int'(out_chan4) != seq[i]) begin
          bad++;
          $display("FAIL rr_sequence[%0d] got=%0d exp=%0d", i, out_chan4, seq[i]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    in_data4   = {16'hC303, 16'h8001, 16'hA101, 16'h1234};
    in_valid4  = 4'b1111;
    for (int i = 0; i < 7; i++) begin
      mode4      = (i == 0) ? 1'b0 : 1'b1;
      sel4       = 2'd0;
      out_ready4 = (i == 0 || i == 6) ? 1'b1 : 1'b0;
      #1;
      model_step();
      total++;
      if (in_ready4 !== exp_rdy) begin
        bad++;
        $display("FAIL bp_in_ready[%0d] got=%b exp=%b", i, in_ready4, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (out_valid4 !== e.v || out_data4 !== e.d || out_chan4 !== e.c) begin
        bad++;
        $display("FAIL bp_beat[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 i, out_valid4, out_data4, out_chan4, e.v, e.d, e.c);
      end
      if (i > 0 && i < 6) begin
        total++;
        if (out_data4 !== 16'h1234 || out_valid4 !== 1'b1) begin
          bad++;
          $display("FAIL bp_hold[%0d] got v=%b d=%h exp v=1 d=1234", i, out_valid4, out_data4);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      in_valid4  = 4'($urandom);
      out_ready4 = ($urandom_range(0, 3) != 0);
      mode4      = 1'($urandom);
      sel4       = 2'($urandom);
      in_data4   = {$urandom, $urandom};
      #1;
      model_step();
      total++;
      if (in_ready4 !== exp_rdy) begin
        bad++;
        $display("FAIL rand_in_ready[%0d] got=%b exp=%b", i, in_ready4, exp_rdy);
      end
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (out_valid4 !== e.v || out_data4 !== e.d || out_chan4 !== e.c) begin
        bad++;
        $display("FAIL rand_beat[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 i, out_valid4, out_data4, out_chan4, e.v, e.d, e.c);
      end
    end
  endtask

  task automatic test_async_reset();
    mode4      = 1'b1;
    in_valid4  = 4'b1111;
    out_ready4 = 1'b1;
    in_data4   = {16'hC303, 16'h8001, 16'hA101, 16'h1234};
    for (int i = 0; i < 3; i++) begin
      #1;
      model_step();
      @(posedge clk);
      #1;
      e = sbq.pop_front();
      total++;
      if (out_valid4 !== e.v || out_data4 !== e.d || out_chan4 !== e.c) begin
        bad++;
        $display("FAIL areset_stream[%0d] got v=%b d=%h c=%0d exp v=%b d=%h c=%0d",
                 i, out_valid4, out_data4, out_chan4, e.v, e.d, e.c);
      end
    end
    #1;
    rst4_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid4 !== 1'b0 || in_ready4 !== 4'b0000) begin
      bad++;
      $display("FAIL areset_immediate got v=%b rdy=%b exp v=0 rdy=0000", out_valid4, in_ready4);
    end
    @(posedge clk);
    #1;
    rst4_n = 1'b1;
    #1;
    model_step();
    total++;
    if (in_ready4 !== exp_rdy || in_ready4 !== 4'b0001) begin
      bad++;
      $display("FAIL areset_restart_grant got=%b exp=0001", in_ready4);
    end
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    total++;
    if (out_valid4 !== 1'b1 || out_chan4 !== 2'd0 || out_data4 !== e.d) begin
      bad++;
      $display("FAIL areset_restart_beat got v=%b d=%h c=%0d exp v=1 d=%h c=0", out_valid4, out_data4, out_chan4, e.d);
    end
  endtask

  task automatic test_out_of_range();
    in_data3   = {16'h7E02, 16'h5A01, 16'h3C00};
    in_valid3  = 3'b111;
    mode3      = 1'b0;
    sel3       = 2'd3;
    out_ready3 = 1'b1;
    rst3_n     = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (in_ready3 !== 3'b000) begin
        bad++;
        $display("FAIL oor_in_ready[%0d] got=%b exp=000", i, in_ready3);
      end
      @(posedge clk);
      #1;
      total++;
      if (out_valid3 !== 1'b0) begin
        bad++;
        $display("FAIL oor_out_valid[%0d] got=%b exp=0", i, out_valid3);
      end
    end
    sel3 = 2'd2;
    #1;
    total++;
    if (in_ready3 !== 3'b100) begin
      bad++;
      $display("FAIL oor_sel2_in_ready got=%b exp=100", in_ready3);
    end
    @(posedge clk);
    #1;
    total++;
    if (out_valid3 !== 1'b1 || out_data3 !== 16'h7E02 || out_chan3 !== 2'd2) begin
      bad++;
      $display("FAIL oor_sel2_beat got v=%b d=%h c=%0d exp v=1 d=7e02 c=2", out_valid3, out_data3, out_chan3);
    end
  endtask

  initial begin
    rst3_n     = 1'b0;
    in_data3   = 48'h0;
    in_valid3  = 3'b000;
    mode3      = 1'b0;
    sel3       = 2'd0;
    out_ready3 = 1'b0;
    test_reset();
    test_fixed();
    test_round_robin();
    test_backpressure();
    test_random();
    test_async_reset();
    test_out_of_range();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
